// File: rtl/dau_arith_seq.sv
// rtl/dau_arith_seq.sv - signed fixed-point decimal add/sub/compare sequencer for the BCD unit
//
// Sequences comma alignment, magnitude compare, add or ordered subtract and
// operand-B cleanup on the BCD unit; computes result sign, comma and signed
// compare flags locally.
// Build option: DAU_SEQ_KEEP_B_EN leaves operand B aligned in place (no CLR).
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start, i_mode               start request (taken while o_ready), 00 add / 01 sub / 10 cmp / 11 reserved
//   i_sign_a/b, i_comma_pos_a/b   operand signs and comma positions
//   i_addr_a/b                    operand register addresses, A is the destination
//   i_flags_valid, i_gt_flag, i_eq_flag   magnitude flags from the last CMP
//   i_instr_accept, o_instr_valid, o_instr   instruction handshake, {op, f0, f1, f2}
//   o_sign, o_comma_pos           result sign and comma position
//   o_cmp_gt, o_cmp_eq            signed compare result
//   o_err, o_done, o_ready        reserved-mode error, completion pulse, idle
module dau_arith_seq #(
  parameter int COMMA_POS_W = 4,
  parameter int ADDR_W      = 4,
  parameter int OP_W        = 4,
  parameter int INSTR_W     = OP_W + 3*ADDR_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic                   i_sign_a,
  input  logic                   i_sign_b,
  input  logic [COMMA_POS_W-1:0] i_comma_pos_a,
  input  logic [COMMA_POS_W-1:0] i_comma_pos_b,
  input  logic [ADDR_W-1:0]      i_addr_a,
  input  logic [ADDR_W-1:0]      i_addr_b,
  input  logic                   i_flags_valid,
  input  logic                   i_gt_flag,
  input  logic                   i_eq_flag,
  input  logic                   i_instr_accept,
  output logic                   o_instr_valid,
  output logic [INSTR_W-1:0]     o_instr,
  output logic                   o_sign,
  output logic [COMMA_POS_W-1:0] o_comma_pos,
  output logic                   o_cmp_gt,
  output logic                   o_cmp_eq,
  output logic                   o_err,
  output logic                   o_done,
  output logic                   o_ready
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(4);
  localparam logic [OP_W-1:0] OP_CLR = OP_W'(5);

  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_CMP = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam int SHAMT_W = 2*ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_CMP, S_WAIT_FLG, S_OP, S_CLR, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]             mode_q;
  logic                   sa_q, sb_q;
  logic [COMMA_POS_W-1:0] ca_q, cb_q;
  logic [ADDR_W-1:0]      aa_q, ab_q;
  logic                   gt_q, eq_q;
  logic                   err_done_q;

  logic                   ready;
  logic                   start_ok;
  logic                   a_shift;
  logic [COMMA_POS_W-1:0] shift_d;
  logic [COMMA_POS_W-1:0] max_comma;
  logic                   subtract;
  logic                   flag_gt, flag_eq;
  logic                   sign_res;
  logic                   cmp_gt_res, cmp_eq_res;

  // DONE doubles as an idle cycle so a back-to-back start is not lost.
  assign ready    = (state == S_IDLE) || (state == S_DONE);
  assign start_ok = i_start && ready;

  // The operand with the smaller comma position is shifted up to the other.
  assign a_shift   = (ca_q < cb_q);
  assign shift_d   = a_shift ? (cb_q - ca_q) : (ca_q - cb_q);
  assign max_comma = a_shift ? cb_q : ca_q;

  // Magnitude subtraction happens when the effective signs differ.
  assign subtract = (mode_q == MODE_SUB) ^ (sa_q ^ sb_q);

  // Results are registered on the edge that enters DONE; coming straight out
  // of WAIT_FLG the flag registers are not loaded yet, so use the live flags.
  assign flag_gt = (state == S_WAIT_FLG) ? i_gt_flag : gt_q;
  assign flag_eq = (state == S_WAIT_FLG) ? i_eq_flag : eq_q;

  always_comb begin
    sign_res = 1'b0;
    if (subtract && flag_eq)
      sign_res = 1'b0;
    else if (flag_gt || !subtract)
      sign_res = sa_q;
    else
      sign_res = (mode_q == MODE_SUB) ^ sb_q;
  end

  always_comb begin
    cmp_gt_res = 1'b0;
    cmp_eq_res = 1'b0;
    if (sa_q != sb_q) begin
      cmp_gt_res = ~sa_q;
    end else begin
      cmp_eq_res = flag_eq;
      cmp_gt_res = !flag_eq && (flag_gt ^ sa_q);
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (i_start && (i_mode != MODE_RSV))
          state_nxt = (i_comma_pos_a == i_comma_pos_b) ? S_CMP : S_ALIGN;
      end
      S_ALIGN:    if (i_instr_accept) state_nxt = S_CMP;
      S_CMP:      if (i_instr_accept) state_nxt = S_WAIT_FLG;
      S_WAIT_FLG: if (i_flags_valid)  state_nxt = (mode_q == MODE_CMP) ? S_DONE : S_OP;
`ifdef DAU_SEQ_KEEP_B_EN
      S_OP:       if (i_instr_accept) state_nxt = S_DONE;
`else
      S_OP:       if (i_instr_accept) state_nxt = S_CLR;
`endif
      S_CLR:      if (i_instr_accept) state_nxt = S_DONE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the instruction is a pure function of state and latched
  // operands, so it stays stable until the BCD unit accepts it.
  always_comb begin
    o_instr_valid = 1'b0;
    o_instr       = {OP_NOP, {3*ADDR_W{1'b0}}};
    case (state)
      S_ALIGN: begin
        o_instr_valid = 1'b1;
        o_instr = {OP_SHL, (a_shift ? aa_q : ab_q), 2'b10, SHAMT_W'(shift_d)};
      end
      S_CMP: begin
        o_instr_valid = 1'b1;
        o_instr = {OP_CMP, aa_q, ab_q, {ADDR_W{1'b0}}};
      end
      S_OP: begin
        o_instr_valid = 1'b1;
        if (!subtract)
          o_instr = {OP_ADD, aa_q, aa_q, ab_q};
        else if (gt_q || eq_q)
          o_instr = {OP_SUB, aa_q, aa_q, ab_q};
        else
          o_instr = {OP_SUB, aa_q, ab_q, aa_q};
      end
      S_CLR: begin
        o_instr_valid = 1'b1;
        o_instr = {OP_CLR, ab_q, {2*ADDR_W{1'b0}}};
      end
      default: ;
    endcase
  end

  assign o_ready = ready;
  assign o_done  = (state == S_DONE) || err_done_q;

  // Operand latches, flags and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q      <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      ca_q        <= '0;
      cb_q        <= '0;
      aa_q        <= '0;
      ab_q        <= '0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      err_done_q  <= 1'b0;
      o_err       <= 1'b0;
      o_sign      <= 1'b0;
      o_comma_pos <= '0;
      o_cmp_gt    <= 1'b0;
      o_cmp_eq    <= 1'b0;
    end else begin
      err_done_q <= 1'b0;
      if (start_ok) begin
        mode_q     <= i_mode;
        sa_q       <= i_sign_a;
        sb_q       <= i_sign_b;
        ca_q       <= i_comma_pos_a;
        cb_q       <= i_comma_pos_b;
        aa_q       <= i_addr_a;
        ab_q       <= i_addr_b;
        o_err      <= (i_mode == MODE_RSV);
        err_done_q <= (i_mode == MODE_RSV);
      end
      if ((state == S_WAIT_FLG) && i_flags_valid) begin
        gt_q <= i_gt_flag;
        eq_q <= i_eq_flag;
      end
      if (state_nxt == S_DONE) begin
        o_comma_pos <= max_comma;
        if (mode_q == MODE_CMP) begin
          o_cmp_gt <= cmp_gt_res;
          o_cmp_eq <= cmp_eq_res;
        end else begin
          o_sign <= sign_res;
        end
      end
    end
  end

endmodule
